// File: rtl/interrupt_pkg.sv
// rtl/interrupt_pkg.sv - shared sizes, FSM state type and priority helper for interrupt_unit
package interrupt_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IRQ_ID_W = 3;
  localparam logic [NUM_IRQ-1:0] MASK_RESET = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } irq_state_t;

  // Lowest set index wins: line 0 has the highest priority.
  function automatic logic [IRQ_ID_W-1:0] first_set(input logic [NUM_IRQ-1:0] v);
    first_set = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) first_set = i[IRQ_ID_W-1:0];
    end
  endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// rtl/interrupt_unit_if.sv - controller-side mask/acknowledge/request bundle for interrupt_unit
interface interrupt_unit_if;
  import interrupt_pkg::*;

  logic                MaskWE;
  logic [NUM_IRQ-1:0]  MaskWD;
  logic                IntReset;
  logic                Interrupt;
  logic [IRQ_ID_W-1:0] IntID;
  logic [NUM_IRQ-1:0]  IntPending;
  logic [NUM_IRQ-1:0]  IntMask;

  modport master (
    output MaskWE, MaskWD, IntReset,
    input  Interrupt, IntID, IntPending, IntMask
  );

  modport slave (
    input  MaskWE, MaskWD, IntReset,
    output Interrupt, IntID, IntPending, IntMask
  );
endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - one request line: optional 2-flop synchronizer (IRQ_SYNC_EN) plus rising-edge detect
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic sampled;
  logic prev;

`ifdef IRQ_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= 1'b0;
      sampled <= 1'b0;
    end else begin
      meta    <= irq;
      sampled <= meta;
    end
  end
`else
  assign sampled = irq;
`endif

  // prev resets low so a line already high at reset release reads as a fresh edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= sampled;
  end

  assign rise = sampled & ~prev;

endmodule

// File: rtl/interrupt_unit.sv
// rtl/interrupt_unit.sv - 8-line masked, fixed-priority, non-preemptive interrupt unit; IRQ_SYNC_EN adds input synchronizers
module interrupt_unit
  import interrupt_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                MaskWE,
  input  logic [NUM_IRQ-1:0]  MaskWD,
  input  logic                IntReset,
  output logic                Interrupt,
  output logic [IRQ_ID_W-1:0] IntID,
  output logic [NUM_IRQ-1:0]  IntPending,
  output logic [NUM_IRQ-1:0]  IntMask
);

  irq_state_t         state;
  irq_state_t         state_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_in[g]),
      .rise  (rise[g])
    );
  end

  assign eligible = IntPending & IntMask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr        = '0;
    case (state)
      IDLE:    if (|eligible) state_next = ASSERT;
      ASSERT:  if (IntReset) state_next = CLEAR;
      CLEAR: begin
        clr[IntID] = 1'b1;
        state_next = HOLDOFF;
      end
      HOLDOFF: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge is ORed in after the clear so it survives a same-cycle service clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Interrupt  <= 1'b0;
      IntID      <= '0;
      IntPending <= '0;
      IntMask    <= MASK_RESET;
    end else begin
      Interrupt  <= (state_next == ASSERT);
      if (state == IDLE && |eligible) IntID <= first_set(eligible);
      IntPending <= (IntPending & ~clr) | rise;
      if (MaskWE) IntMask <= MaskWD;
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// tb/tb_interrupt_unit.sv - directed plus randomized checks of interrupt_unit against a behavioural model
module tb_interrupt_unit;

`ifdef IRQ_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq_in = 8'h00;
  int         vectors = 0;
  int         miscompares = 0;

  interrupt_unit_if ifc ();

  interrupt_unit dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .MaskWE     (ifc.MaskWE),
    .MaskWD     (ifc.MaskWD),
    .IntReset   (ifc.IntReset),
    .Interrupt  (ifc.Interrupt),
    .IntID      (ifc.IntID),
    .IntPending (ifc.IntPending),
    .IntMask    (ifc.IntMask)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, pending/mask words, and a service record.
  logic [7:0] hist[$];
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  bit         m_busy;
  int         m_cur;
  int         m_gap;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 4; i++) hist.push_back(8'h00);
    m_pend = 8'h00;
    m_mask = 8'hFF;
    m_busy = 0;
    m_cur  = 0;
    m_gap  = 0;
  endtask

  task automatic model_edge(input logic [7:0] irq, input logic we, input logic [7:0] wd, input logic ack);
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] elig;
    hist.push_back(irq);
    rise = hist[hist.size()-1-D] & ~hist[hist.size()-2-D];
    clr  = 8'h00;
    elig = m_pend & m_mask;
    if (m_gap == 2) clr[m_cur] = 1'b1;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        m_gap  = 2;
      end
    end else if (elig != 8'h00) begin
      for (int i = 7; i >= 0; i--) if (elig[i]) m_cur = i;
      m_busy = 1;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (we) m_mask = wd;
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("interrupt", {7'b0, ifc.Interrupt}, {7'b0, m_busy});
    chk("int_id", {5'b0, ifc.IntID}, m_cur[7:0]);
    chk("pending", ifc.IntPending, m_pend);
    chk("mask", ifc.IntMask, m_mask);
  endtask

  task automatic cycle(input logic [7:0] irq, input logic we, input logic [7:0] wd, input logic ack);
    irq_in       = irq;
    ifc.MaskWE   = we;
    ifc.MaskWD   = wd;
    ifc.IntReset = ack;
    @(posedge clk);
    model_edge(irq, we, wd, ack);
    @(negedge clk);
    check_model();
  endtask

  task automatic serve(input logic [7:0] irq, input int exp_id);
    int n = 0;
    while (ifc.Interrupt !== 1'b1 && n < 20) begin
      cycle(irq, 1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("serve_seen", {7'b0, ifc.Interrupt}, 8'h01);
    chk("serve_id", {5'b0, ifc.IntID}, exp_id[7:0]);
    cycle(irq, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] r_irq;
    ifc.MaskWE   = 1'b0;
    ifc.MaskWD   = 8'h00;
    ifc.IntReset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b1;

    // Single request on line 2, timed edge by edge.
    idle(2);
    for (int k = 1; k <= LAT + 1; k++) begin
      cycle(8'h04, 1'b0, 8'h00, 1'b0);
      if (k == LAT) begin
        chk("single_pend", ifc.IntPending, 8'h04);
        chk("single_noint", {7'b0, ifc.Interrupt}, 8'h00);
      end
    end
    chk("single_int", {7'b0, ifc.Interrupt}, 8'h01);
    chk("single_id", {5'b0, ifc.IntID}, 8'h02);
    cycle(8'h04, 1'b0, 8'h00, 1'b0);
    cycle(8'h04, 1'b0, 8'h00, 1'b1);
    chk("ack_int0", {7'b0, ifc.Interrupt}, 8'h00);
    cycle(8'h04, 1'b0, 8'h00, 1'b0);
    chk("ack_pend0", ifc.IntPending, 8'h00);
    cycle(8'h04, 1'b0, 8'h00, 1'b0);
    chk("holdoff_int0", {7'b0, ifc.Interrupt}, 8'h00);
    idle(4);

    // Simultaneous lines 4 and 7: 4 first.
    cycle(8'h90, 1'b0, 8'h00, 1'b0);
    serve(8'h90, 4);
    serve(8'h90, 7);
    idle(4);

    // Masked line 0 stays pending until the mask is reopened.
    cycle(8'h00, 1'b1, 8'hFE, 1'b0);
    for (int k = 0; k < LAT + 3; k++) cycle(8'h01, 1'b0, 8'h00, 1'b0);
    chk("masked_pend", ifc.IntPending, 8'h01);
    chk("masked_noint", {7'b0, ifc.Interrupt}, 8'h00);
    cycle(8'h01, 1'b1, 8'hFF, 1'b0);
    serve(8'h01, 0);
    idle(4);

    // New edge on line 3 lands on its own CLEAR edge.
    for (int k = 0; k < 20 && ifc.Interrupt !== 1'b1; k++) cycle(8'h08, 1'b0, 8'h00, 1'b0);
    chk("coll_id", {5'b0, ifc.IntID}, 8'h03);
    for (int k = 0; k < 4; k++) cycle(8'h00, 1'b0, 8'h00, 1'b0);
    for (int rel = -3; rel <= 3; rel++) begin
      cycle((rel >= 1 - D) ? 8'h08 : 8'h00, 1'b0, 8'h00, rel == 0);
      if (rel == 1) chk("coll_pend", ifc.IntPending & 8'h08, 8'h08);
    end
    serve(8'h08, 3);
    idle(4);

    // Line 1 arriving during service of line 5 does not preempt.
    for (int k = 0; k < 20 && ifc.Interrupt !== 1'b1; k++) cycle(8'h20, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < LAT + 3; k++) cycle(8'h22, 1'b0, 8'h00, 1'b0);
    chk("nopre_id", {5'b0, ifc.IntID}, 8'h05);
    chk("nopre_int", {7'b0, ifc.Interrupt}, 8'h01);
    cycle(8'h22, 1'b1, 8'h00, 1'b0);
    chk("nopre_mask_id", {5'b0, ifc.IntID}, 8'h05);
    cycle(8'h22, 1'b1, 8'hFF, 1'b1);
    serve(8'h22, 1);
    idle(4);

    // Randomized traffic.
    r_irq = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic       we;
      logic [7:0] wd;
      logic       ack;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
      we  = ($urandom_range(0, 15) == 0);
      wd  = 8'($urandom);
      ack = (ifc.Interrupt === 1'b1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      cycle(r_irq, we, wd, ack);
    end
    cycle(8'h00, 1'b1, 8'hFF, 1'b0);
    idle(8);

    // Asynchronous reset while a request is asserted.
    for (int k = 0; k < 20 && ifc.Interrupt !== 1'b1; k++) cycle(8'h40, 1'b0, 8'h00, 1'b0);
    chk("pre_reset_int", {7'b0, ifc.Interrupt}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    serve(8'h40, 6);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
INTERRUPT_UNIT -- requirements
Module: interrupt_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port irq_in, input, 8 bits: asynchronous peripheral request lines, active-high, rising-edge significant.
REQ-004 SHALL have port MaskWE, input, 1 bit: mask register write enable.
REQ-005 SHALL have port MaskWD, input, 8 bits: mask write data; bit i = 1 enables line i.
REQ-006 SHALL have port IntReset, input, 1 bit: acknowledge from the controller that the interrupt was taken.
REQ-007 SHALL have port Interrupt, output, 1 bit: request to the controller, registered.
REQ-008 SHALL have port IntID, output, 3 bits: index of the line being serviced, registered, stable while Interrupt = 1.
REQ-009 SHALL have port IntPending, output, 8 bits: raw pending register, unmasked view.
REQ-010 SHALL have port IntMask, output, 8 bits: current mask register.

Function
REQ-011 SHALL set pending[i] on a detected 0->1 transition of synchronized irq_in[i]; pending bits are sticky until cleared by service.
REQ-012 SHALL use eligible = pending & mask, with priority lowest index first (line 0 highest).
REQ-013 SHALL implement FSM states IDLE, ASSERT, CLEAR, HOLDOFF.
REQ-014 IDLE: when eligible != 0, latch IntID = highest-priority index and go to ASSERT at the next edge; otherwise stay in IDLE.
REQ-015 ASSERT: Interrupt = 1 and IntID is held; stay until IntReset = 1, then go to CLEAR.
REQ-016 ASSERT: a masking write or a higher-priority arrival SHALL NOT change IntID or deassert Interrupt (no preemption).
REQ-017 CLEAR: clear pending[IntID]; Interrupt = 0; go to HOLDOFF.
REQ-018 HOLDOFF: one cycle with Interrupt = 0 so the controller observes the deassertion; then go to IDLE.
REQ-019 A new edge on line i in the same cycle that CLEAR clears pending[i] SHALL win: the bit stays set.
REQ-020 IntReset outside ASSERT SHALL be ignored.
REQ-021 MaskWE = 1 SHALL load MaskWD into mask at the next edge in any state; pending bits of masked lines are retained.
REQ-022 Latency: with sync enabled, pending[i] is set at the 3rd rising edge after irq_in[i] rises, and Interrupt asserts at the following edge (4 edges total from IDLE).
REQ-023 Lines held high SHALL NOT re-trigger; a new request requires a low phase of at least 1 synchronized sample.

Reset
REQ-024 With reset = 0, asynchronously: state = IDLE, Interrupt = 0, IntID = 0, pending = 0, mask = 8'hFF, synchronizer and edge flops = 0.
REQ-025 Deassertion of reset mid-request SHALL cause lines already high to be taken as rising edges once sampled.

Configuration
REQ-026 Macro IRQ_SYNC_EN: when defined, each irq_in line passes through a 2-flop synchronizer before edge detection (REQ-022 latency).
REQ-027 Without IRQ_SYNC_EN, irq_in is treated as synchronous: edge detect uses irq_in directly against the previous sample, pending is set at the 1st edge, and Interrupt asserts at the 2nd edge.

Structure
REQ-028 Package interrupt_pkg SHALL hold NUM_IRQ = 8, IRQ_ID_W = 3, the FSM state enum type, and MASK_RESET = 8'hFF.
REQ-029 Sub-module irq_sync SHALL implement one line's optional synchronizer plus rising-edge detector; interrupt_unit SHALL instantiate it NUM_IRQ times.

Verification
REQ-030 Single request (sync on): irq_in = 8'h04 held -> IntPending[2] = 1 at edge 3, Interrupt = 1 with IntID = 2 at edge 4; IntReset pulse -> pending[2] = 0 and Interrupt = 0 for the 2 following cycles.
REQ-031 Priority: irq_in = 8'h90 in the same cycle -> IntID = 4 serviced first, then IntID = 7 after HOLDOFF.
REQ-032 Masking: write mask 8'hFE, raise irq_in[0] -> pending[0] = 1 with no Interrupt; write mask 8'hFF -> Interrupt with IntID = 0.
REQ-033 Clear collision: re-raise line 3 so its edge lands on the CLEAR cycle of IntID = 3 -> pending[3] remains 1 and the line is serviced again.
REQ-034 Reset mid-ASSERT: drop reset while Interrupt = 1 -> all outputs return to their reset values immediately, without waiting for a clock edge.
REQ-035 No preemption: while IntID = 5 is asserted, raise line 1 -> IntID stays 5 until IntReset; line 1 is serviced next.
